// File: rtl/seq_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, decode-side valid/ready
// stream, execute redirect and status flags.
interface seq_fetch_unit_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 10
);
  logic            imem_req;
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            halted;
  logic            misalign_err;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr, halted, misalign_err,
    input  imem_rdata, out_ready, redir_valid, redir_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, halted, misalign_err,
    output imem_rdata, out_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/seq_fetch_unit.sv
// Sequential RV64 fetch stage: PC owner, 1-cycle imem reads, 2-entry output queue, redirect/halt.
// Optional FETCH_PERF_EN adds perf_fetched/perf_stall counters.
module seq_fetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     AW       = 10
) (
  input  logic               clk,
  input  logic               reset,
  seq_fetch_unit_if.master   bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam logic [31:0] Ecall  = 32'h0000_0073;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic            infl_q, infl_d;
  logic            infl_epoch_q;
  logic [XLEN-1:0] infl_pc_q;
  logic [XLEN-1:0] q_pc_q    [2];
  logic [31:0]     q_instr_q [2];
  logic            head_q, head_d;
  logic [1:0]      count_q, count_d;
  logic            misalign_q, misalign_d;

  logic       pop, push, issue, halt_word, tail;
  logic [2:0] occupancy;

  assign pop       = (count_q != 2'd0) && bus.out_ready;
  // Responses tagged with a stale epoch belong to a killed request.
  assign push      = infl_q && (infl_epoch_q == epoch_q) && !bus.redir_valid;
  assign halt_word = push && ((bus.imem_rdata == Ecall) || (bus.imem_rdata == Ebreak));
  assign occupancy = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue     = (state_q == StRun) && !bus.redir_valid && !reset && (occupancy < 3'd2);
  assign tail      = head_q ^ count_q[0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    infl_d     = 1'b0;
    head_d     = head_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    if (bus.redir_valid) begin
      state_d    = StRun;
      pc_d       = {bus.redir_pc[XLEN-1:2], 2'b00};
      epoch_d    = ~epoch_q;
      head_d     = 1'b0;
      count_d    = 2'd0;
      misalign_d = misalign_q | (bus.redir_pc[1:0] != 2'b00);
    end else begin
      infl_d  = issue;
      head_d  = head_q ^ pop;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (issue) begin
        pc_d = pc_q + XLEN'(4);
      end
      // The request issued alongside the halting word is younger; flipping the epoch kills it.
      if (halt_word) begin
        state_d = StHalt;
        epoch_d = ~epoch_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      epoch_q      <= 1'b0;
      infl_q       <= 1'b0;
      infl_epoch_q <= 1'b0;
      infl_pc_q    <= '0;
      head_q       <= 1'b0;
      count_q      <= 2'd0;
      misalign_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epoch_q      <= epoch_d;
      infl_q       <= infl_d;
      infl_epoch_q <= epoch_q;
      infl_pc_q    <= pc_q;
      head_q       <= head_d;
      count_q      <= count_d;
      misalign_q   <= misalign_d;
      if (push) begin
        q_pc_q[tail]    <= infl_pc_q;
        q_instr_q[tail] <= bus.imem_rdata;
      end
    end
  end

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = pc_q[AW+1:2];
  assign bus.out_valid    = (count_q != 2'd0);
  assign bus.out_pc       = bus.out_valid ? q_pc_q[head_q] : '0;
  assign bus.out_instr    = bus.out_valid ? q_instr_q[head_q] : '0;
  assign bus.halted       = (state_q == StHalt);
  assign bus.misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (bus.out_valid && !bus.out_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_fetch_unit.sv
// Scoreboard bench for seq_fetch_unit: directed scenarios push expected {pc, instr}
// entries; a negedge monitor compares every decode handshake against them.
module tb_seq_fetch_unit;
  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_fetch_unit_if #(.XLEN(XLEN), .AW(AW)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  seq_fetch_unit #(
    .XLEN(XLEN),
    .RESET_PC(64'h0),
    .AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall)
`endif
  );

  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
  end

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int hs_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      hs_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got pc %0h instr %0h, expected none",
                 bus.out_pc, bus.out_instr);
      end else begin
        e = exp_q.pop_front();
        if ({bus.out_pc, bus.out_instr} !== e) begin
          errors++;
          $display("FAIL output_order: got pc %0h instr %0h, expected pc %0h instr %0h",
                   bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory holds word i at word address i.
  task automatic expect_seq(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({start + 64'(4 * i), 32'((start >> 2) + 64'(i))});
    end
  endtask

  task automatic redirect(input logic [63:0] tgt);
    bus.redir_valid = 1'b1;
    bus.redir_pc    = tgt;
    step();
    bus.redir_valid = 1'b0;
  endtask

  initial begin
    int h0;
    int n;
    int reqs;
    logic [63:0] pc0;
    logic [31:0] ins0;
    logic stable;
    logic gaps;

    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    reset           = 1'b1;
    bus.out_ready   = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = '0;
    step(2);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_misalign", bus.misalign_err, 0);

    // 1: streaming from reset
    bus.out_ready = 1'b1;
    expect_seq(64'h0, 40);
    reset = 1'b0;
    step(1);
    chk("s1_not_yet_valid", bus.out_valid, 0);
    step(1);
    chk("s1_first_valid", bus.out_valid, 1);
    chk("s1_first_pc", bus.out_pc, 64'h0);
    gaps = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (!bus.out_valid) gaps = 1'b1;
    end
    chk("s1_no_gaps", gaps, 0);
    chk("s1_throughput", hs_count, 6);

    // 2: stall holds output stable and fills the queue
    bus.out_ready = 1'b0;
    chk("s2_head_pc", bus.out_pc, 64'h18);
    pc0    = bus.out_pc;
    ins0   = bus.out_instr;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (bus.out_pc !== pc0 || bus.out_instr !== ins0 || !bus.out_valid) stable = 1'b0;
    end
    chk("s2_stable", stable, 1);
    chk("s2_full_no_req", bus.imem_req, 0);
`ifdef FETCH_PERF_EN
    chk("s2_perf_stall", perf_stall, 5);
`endif
    bus.out_ready = 1'b1;
    h0 = hs_count;
    step(4);
    chk("s2_release_rate", hs_count - h0, 4);

    // 3: redirect while queue is full
    bus.out_ready = 1'b0;
    step(3);
    chk("s3_pre_full_no_req", bus.imem_req, 0);
    exp_q.delete();
    redirect(64'h100);
    chk("s3_flush", bus.out_valid, 0);
    expect_seq(64'h100, 20);
    bus.out_ready = 1'b1;
    step(1);
    chk("s3_latency", bus.out_valid, 0);
    step(1);
    chk("s3_first_valid", bus.out_valid, 1);
    chk("s3_first_pc", bus.out_pc, 64'h100);
    h0 = hs_count;
    step(5);
    chk("s3_stream", hs_count - h0, 5);

    // 4: ECALL halts fetch; redirect resumes
    bus.out_ready = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    mem[2] = 32'h0000_0073;
    step(1);
    exp_q.push_back({64'h0, 32'h0});
    exp_q.push_back({64'h4, 32'h1});
    exp_q.push_back({64'h8, 32'h0000_0073});
    bus.out_ready = 1'b1;
    reset = 1'b0;
    n = 0;
    while (!bus.halted && n < 20) begin
      step(1);
      n++;
    end
    chk("s4_halted", bus.halted, 1);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.imem_req) reqs++;
    end
    chk("s4_no_req", reqs, 0);
    chk("s4_drained", exp_q.size(), 0);
    chk("s4_empty", bus.out_valid, 0);
    chk("s4_still_halted", bus.halted, 1);
    expect_seq(64'h40, 10);
    redirect(64'h40);
    chk("s4_resume", bus.halted, 0);
    step(2);
    chk("s4_resume_pc", bus.out_pc, 64'h40);
    step(3);

    // 5: misaligned redirect
    bus.out_ready = 1'b0;
    step(2);
    exp_q.delete();
    redirect(64'h102);
    chk("s5_misalign", bus.misalign_err, 1);
    expect_seq(64'h100, 10);
    bus.out_ready = 1'b1;
    step(2);
    chk("s5_aligned_pc", bus.out_pc, 64'h100);
    step(3);
    bus.out_ready = 1'b0;
    step(2);
    exp_q.delete();
    redirect(64'h200);
    chk("s5_sticky", bus.misalign_err, 1);
    expect_seq(64'h200, 10);
    bus.out_ready = 1'b1;
    step(4);

    // 6: reset mid-stream with full queue
    bus.out_ready = 1'b0;
    step(3);
    chk("s6_pre_full", bus.out_valid, 1);
    exp_q.delete();
    reset = 1'b1;
    #1;
    chk("s6_async_valid", bus.out_valid, 0);
    chk("s6_async_misalign", bus.misalign_err, 0);
    chk("s6_async_req", bus.imem_req, 0);
    mem[2] = 32'h2;
    step(1);
    expect_seq(64'h0, 10);
    bus.out_ready = 1'b1;
    reset = 1'b0;
    step(1);
    chk("s6_not_yet_valid", bus.out_valid, 0);
    step(1);
    chk("s6_restart_pc", bus.out_pc, 64'h0);
    h0 = hs_count;
    step(4);
    chk("s6_stream", hs_count - h0, 4);

    bus.out_ready = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
